// File: rtl/ahb_gnss_search_sequencer_pkg.sv
// Shared GNSS search register map, status bits and bus/sequencer types.
package ahb_gnss_search_sequencer_pkg;
  typedef logic [4:0]  sv_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {HT_IDLE = 2'b00, HT_NONSEQ = 2'b10} htrans_t;

  localparam word_t SEARCH_STATUS = 32'h0;
  localparam word_t SEARCH_SV     = 32'h4;
  localparam word_t SEARCH_DOP    = 32'h8;
  localparam word_t SEARCH_CODE   = 32'hC;
  localparam word_t SEARCH_CORR   = 32'h10;

  localparam int STAT_START = 0;
  localparam int STAT_DONE  = 1;

  // Writing both bits kicks off a search and clears the stale done flag.
  localparam word_t START_CMD = (word_t'(1) << STAT_START) | (word_t'(1) << STAT_DONE);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SV, S_WR_START, S_GAP, S_RD_STATUS,
    S_RD_DOP, S_RD_CODE, S_RD_CORR, S_EMIT, S_FINISH
  } seq_state_t;
endpackage

// File: rtl/ahb_gnss_search_sequencer_ahb_single_master.sv
// Single-outstanding AHB-Lite transfer engine: address phase, then data phase.
module ahb_single_master
  import ahb_gnss_search_sequencer_pkg::*;
(
  input  logic       hclk,
  input  logic       rst,
  input  logic       req,
  input  word_t      addr,
  input  logic       write,
  input  word_t      wdata,
  output logic       done,
  output word_t      rdata,
  output logic       err,
  output word_t      haddr,
  output logic [1:0] htrans,
  output logic       hwrite,
  output word_t      hwdata,
  input  word_t      hrdata,
  input  logic       hready,
  input  logic       hresp
);
  typedef enum logic [1:0] {E_IDLE, E_ADDR, E_DATA} phase_t;
  phase_t phase;

  always_ff @(posedge hclk) begin
    if (rst) begin
      phase  <= E_IDLE;
      haddr  <= '0;
      htrans <= HT_IDLE;
      hwrite <= 1'b0;
      hwdata <= '0;
      done   <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (phase)
        // req is still high in the cycle done pulses; don't re-issue it.
        E_IDLE: if (req && !done) begin
          haddr  <= addr;
          hwrite <= write;
          htrans <= HT_NONSEQ;
          if (write) hwdata <= wdata;
          phase  <= E_ADDR;
        end
        E_ADDR: if (hready) begin
          htrans <= HT_IDLE;
          phase  <= E_DATA;
        end
        E_DATA: if (hresp) begin
          done  <= 1'b1;
          err   <= 1'b1;
          phase <= E_IDLE;
        end else if (hready) begin
          done  <= 1'b1;
          rdata <= hrdata;
          phase <= E_IDLE;
        end
        default: phase <= E_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ahb_gnss_search_sequencer.sv
// AHB manager sweeping a PRN range through the GNSS search block, one record per SV.
module ahb_gnss_search_sequencer
  import ahb_gnss_search_sequencer_pkg::*;
#(
  parameter word_t BASE_ADDR  = 32'h2004_0100,
  parameter int    POLL_GAP   = 16,
  parameter int    POLL_LIMIT = 4096
)(
  input  logic        hclk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  sv_first,
  input  logic [4:0]  sv_last,
  output logic        busy,
  output logic        sweep_done,
  output logic        bus_err,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [1:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_sv,
  output logic [31:0] res_dop,
  output logic [31:0] res_code,
  output logic [31:0] res_corr,
  output logic        res_timeout
);
  seq_state_t  state;
  sv_t         cur_sv, last_sv;
  logic [15:0] gap_cnt, polls;
  logic        req, write, done, err;
  word_t       addr, wdata, rdata;

  assign hsize  = 2'b10;
  assign hburst = 3'b000;

  always_comb begin
    req   = 1'b1;
    write = 1'b0;
    wdata = '0;
    addr  = BASE_ADDR + SEARCH_STATUS;
    case (state)
      S_WR_SV:     begin write = 1'b1; addr = BASE_ADDR + SEARCH_SV; wdata = {27'b0, cur_sv}; end
      S_WR_START:  begin write = 1'b1; wdata = START_CMD; end
      S_RD_STATUS: ;
      S_RD_DOP:    addr = BASE_ADDR + SEARCH_DOP;
      S_RD_CODE:   addr = BASE_ADDR + SEARCH_CODE;
      S_RD_CORR:   addr = BASE_ADDR + SEARCH_CORR;
      default:     req = 1'b0;
    endcase
  end

  ahb_single_master u_mst (
    .hclk, .rst, .req, .addr, .write, .wdata, .done, .rdata, .err,
    .haddr, .htrans, .hwrite, .hwdata, .hrdata, .hready, .hresp
  );

  always_ff @(posedge hclk) begin
    if (rst) begin
      state <= S_IDLE;
      cur_sv <= '0; last_sv <= '0; gap_cnt <= '0; polls <= '0;
      busy <= 1'b0; sweep_done <= 1'b0; bus_err <= 1'b0;
      res_valid <= 1'b0; res_sv <= '0; res_dop <= '0; res_code <= '0;
      res_corr <= '0; res_timeout <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      // An error response ends the sweep from any bus state; the SV gets no record.
      if (done && err) begin
        bus_err    <= 1'b1;
        sweep_done <= 1'b1;
        state      <= S_FINISH;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            cur_sv  <= sv_first;
            last_sv <= (sv_first > sv_last) ? sv_first : sv_last;
            bus_err <= 1'b0;
            busy    <= 1'b1;
            state   <= S_WR_SV;
          end
          S_WR_SV: if (done) state <= S_WR_START;
          S_WR_START: if (done) begin
            polls   <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end
          S_GAP: begin
            gap_cnt <= gap_cnt + 16'd1;
            if (gap_cnt == 16'(POLL_GAP - 1)) state <= S_RD_STATUS;
          end
          S_RD_STATUS: if (done) begin
            if (rdata[STAT_DONE]) state <= S_RD_DOP;
            else if (polls == 16'(POLL_LIMIT - 1)) begin
              res_timeout <= 1'b1;
              res_dop <= '0; res_code <= '0; res_corr <= '0;
              res_sv <= cur_sv; res_valid <= 1'b1;
              state <= S_EMIT;
            end else begin
              polls   <= polls + 16'd1;
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end
          S_RD_DOP:  if (done) begin res_dop  <= rdata; state <= S_RD_CODE; end
          S_RD_CODE: if (done) begin res_code <= rdata; state <= S_RD_CORR; end
          S_RD_CORR: if (done) begin
            res_corr <= rdata; res_timeout <= 1'b0;
            res_sv <= cur_sv; res_valid <= 1'b1;
            state <= S_EMIT;
          end
          // Equality test (not wrap) ends a sweep that reaches SV 31.
          S_EMIT: if (res_ready) begin
            res_valid <= 1'b0;
            if (cur_sv == last_sv) begin
              sweep_done <= 1'b1;
              state      <= S_FINISH;
            end else begin
              cur_sv <= cur_sv + 5'd1;
              state  <= S_WR_SV;
            end
          end
          S_FINISH: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ahb_gnss_search_sequencer.sv
// Bench: AHB subordinate model of the search block, record scoreboard, bus trace checks.
module tb_ahb_gnss_search_sequencer;
  localparam logic [31:0] BASE  = 32'h2004_0100;
  localparam logic [31:0] NOERR = 32'hFFFF_FFFF;

  logic        hclk = 0, rst = 1, start = 0;
  logic [4:0]  sv_first = 0, sv_last = 0;
  logic        busy, sweep_done, bus_err, hwrite;
  logic [31:0] haddr, hwdata, hrdata = 0;
  logic [1:0]  htrans, hsize;
  logic [2:0]  hburst;
  logic        hready = 1, hresp = 0, res_valid, res_ready = 0, res_timeout;
  logic [4:0]  res_sv;
  logic [31:0] res_dop, res_code, res_corr;

  ahb_gnss_search_sequencer #(.BASE_ADDR(BASE), .POLL_GAP(2), .POLL_LIMIT(4)) dut (
    .hclk(hclk), .rst(rst), .start(start), .sv_first(sv_first), .sv_last(sv_last),
    .busy(busy), .sweep_done(sweep_done), .bus_err(bus_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .res_valid(res_valid), .res_ready(res_ready), .res_sv(res_sv), .res_dop(res_dop),
    .res_code(res_code), .res_corr(res_corr), .res_timeout(res_timeout)
  );

  always #5 hclk = ~hclk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] dop_of(input logic [4:0] s);  return 32'hD0B0_0000 | 32'(s); endfunction
  function automatic logic [31:0] code_of(input logic [4:0] s); return 32'hC0DE_0000 | 32'(s); endfunction
  function automatic logic [31:0] corr_of(input logic [4:0] s); return 32'hC0AA_0000 | 32'(s); endfunction
  function automatic logic [127:0] exp_rec(input logic [4:0] s, input bit to);
    if (to) return {26'b0, s, 96'b0, 1'b1};
    return {26'b0, s, dop_of(s), code_of(s), corr_of(s), 1'b0};
  endfunction

  wire [127:0] rec_now = {26'b0, res_sv, res_dop, res_code, res_corr, res_timeout};

  // test knobs, changed only between sweeps
  int          done_after = 1, hold_cfg = 0;
  bit          stall_en = 0;
  logic [31:0] err_addr = NOERR;

  logic [127:0] sb[$];
  logic [64:0]  trace[$];   // {write, addr, wdata-or-0}

  // subordinate model: decides hready/hresp/hrdata at each negedge for the coming edge
  bit          dp_active = 0, dp_write = 0, a_pend = 0, err_phase = 0;
  bit          last_hready = 1, last_nonseq = 0, last_hwrite = 0;
  logic [31:0] dp_addr = 0, last_haddr = 0, last_hwdata = 0;
  int          a_wait = 0, d_wait = 0, polls = 0;
  logic [4:0]  sv_reg = 0;
  initial begin
    forever begin
      @(negedge hclk);
      if (rst) begin
        dp_active = 0; a_pend = 0; err_phase = 0;
        hready = 1; hresp = 0; last_hready = 1; last_nonseq = 0;
      end else begin
        if (!last_hready && last_nonseq)
          chk("addr_hold", {htrans, hwrite, haddr}, {2'b10, last_hwrite, last_haddr});
        if (!last_hready && dp_active && dp_write && !err_phase)
          chk("wdata_hold", hwdata, last_hwdata);
        last_nonseq = (htrans == 2'b10) && !dp_active;
        last_haddr = haddr; last_hwrite = hwrite; last_hwdata = hwdata;
        if (!dp_active) begin
          hresp = 0;
          if (htrans == 2'b10) begin
            if (!a_pend) begin a_pend = 1; a_wait = stall_en ? int'($urandom_range(0, 3)) : 0; end
            if (a_wait != 0) begin hready = 0; a_wait--; end
            else begin
              hready = 1; a_pend = 0; dp_active = 1; dp_addr = haddr; dp_write = hwrite;
              d_wait = stall_en ? int'($urandom_range(0, 3)) : 0;
            end
          end else hready = 1;
        end else if (err_phase) begin
          hready = 1; hresp = 1; err_phase = 0; dp_active = 0;
        end else if (d_wait != 0) begin
          hready = 0; d_wait--;
        end else if (!dp_write && dp_addr == err_addr) begin
          hready = 0; hresp = 1; err_phase = 1;
        end else begin
          hready = 1; hresp = 0; dp_active = 0;
          if (dp_write) begin
            trace.push_back({1'b1, dp_addr, hwdata});
            if (dp_addr == BASE + 32'h4) sv_reg = hwdata[4:0];
            if (dp_addr == BASE && hwdata == 32'h3) polls = 0;
          end else begin
            trace.push_back({1'b0, dp_addr, 32'h0});
            case (dp_addr)
              BASE: begin polls++; hrdata = (done_after != 0 && polls >= done_after) ? 32'h2 : 32'h0; end
              BASE + 32'h8:  hrdata = dop_of(sv_reg);
              BASE + 32'hC:  hrdata = code_of(sv_reg);
              BASE + 32'h10: hrdata = corr_of(sv_reg);
              default:       hrdata = 32'hDEAD_BEEF;
            endcase
          end
        end
        last_hready = hready;
      end
    end
  end

  // result consumer: optional back-pressure, then pop and compare
  bit           in_rec = 0;
  int           hold_left = 0;
  logic [127:0] snap = 0;
  initial begin
    forever begin
      @(negedge hclk);
      if (rst || !res_valid) begin res_ready = 0; in_rec = 0; end
      else begin
        if (!in_rec) begin in_rec = 1; hold_left = hold_cfg; snap = rec_now; end
        else begin chk("rec_stable", rec_now, snap); chk("emit_idle", htrans, 2'b00); end
        if (hold_left > 0) begin res_ready = 0; hold_left--; end
        else begin
          res_ready = 1;
          chk("rec_avail", sb.size() != 0, 1);
          if (sb.size() != 0) chk("rec", rec_now, sb.pop_front());
        end
      end
    end
  end

  task automatic run_sweep(input logic [4:0] f, input logic [4:0] l, input int da, input bit st,
                           input int hold, input logic [31:0] ea, input bit expect_err);
    int last_eff;
    bit seen;
    done_after = da; stall_en = st; hold_cfg = hold; err_addr = ea;
    trace.delete();
    last_eff = (f > l) ? int'(f) : int'(l);
    if (!expect_err)
      for (int s = int'(f); s <= last_eff; s++) sb.push_back(exp_rec(5'(s), da == 0));
    @(negedge hclk); sv_first = f; sv_last = l; start = 1;
    @(negedge hclk); start = 0;
    chk("busy_start", busy, 1);
    chk("err_clr", bus_err, 0);
    seen = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge hclk);
      if (sweep_done) begin seen = 1; break; end
    end
    chk("sweep_done", seen, 1);
    @(negedge hclk);
    chk("sweep_done_pulse", sweep_done, 0);
    chk("busy_end", busy, 0);
    chk("bus_err", bus_err, expect_err);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int n, last_sv_wr;
    bit seen;
    logic [64:0] exp_tr[7];
    repeat (3) @(negedge hclk);
    chk("rst_bus", {htrans, hwrite, haddr, hwdata}, 0);
    chk("rst_ctl", {busy, sweep_done, bus_err, res_valid, res_timeout, res_sv}, 0);
    chk("rst_res", {res_dop, res_code, res_corr}, 0);
    chk("hsize_hburst", {hsize, hburst}, {2'b10, 3'b000});
    rst = 0;

    // single SV, zero wait, done on the second poll
    run_sweep(5'd3, 5'd3, 2, 0, 0, NOERR, 0);
    exp_tr = '{{1'b1, BASE + 32'h4, 32'h3}, {1'b1, BASE, 32'h3}, {1'b0, BASE, 32'h0},
               {1'b0, BASE, 32'h0}, {1'b0, BASE + 32'h8, 32'h0}, {1'b0, BASE + 32'hC, 32'h0},
               {1'b0, BASE + 32'h10, 32'h0}};
    chk("trace_len", trace.size(), 7);
    for (int i = 0; i < 7 && i < trace.size(); i++) chk("trace", trace[i], exp_tr[i]);

    // top of range with random stalls; must stop at 31
    run_sweep(5'd30, 5'd31, 1, 1, 0, NOERR, 0);
    n = 0; last_sv_wr = -1;
    foreach (trace[i]) if (trace[i][64] && trace[i][63:32] == BASE + 32'h4) begin
      n++; last_sv_wr = int'(trace[i][31:0]);
    end
    chk("sv_writes", n, 2);
    chk("last_sv_wr", last_sv_wr, 31);

    // done never set: each SV times out after 4 polls
    run_sweep(5'd5, 5'd6, 0, 0, 0, NOERR, 0);
    n = 0;
    foreach (trace[i]) if (!trace[i][64] && trace[i][63:32] == BASE) n++;
    chk("status_reads", n, 8);

    // error response on the code read: no record, sticky bus_err
    run_sweep(5'd7, 5'd8, 1, 0, 0, BASE + 32'hC, 1);

    // back-pressure on the record with bus stalls; start clears bus_err
    run_sweep(5'd9, 5'd10, 1, 1, 20, NOERR, 0);

    // sv_first > sv_last: single SV
    run_sweep(5'd12, 5'd4, 1, 0, 0, NOERR, 0);

    // reset during the WR_START data phase
    done_after = 1; stall_en = 0; hold_cfg = 0; err_addr = NOERR;
    @(negedge hclk); sv_first = 5'd2; sv_last = 5'd3; start = 1;
    @(negedge hclk); start = 0;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (htrans == 2'b10 && hwrite && haddr == BASE) begin seen = 1; break; end
      @(negedge hclk);
    end
    chk("start_wr_seen", seen, 1);
    @(negedge hclk);
    rst = 1;
    @(negedge hclk);
    chk("rst_mid_bus", {htrans, haddr, hwrite, hwdata}, 0);
    chk("rst_mid_ctl", {busy, res_valid, sweep_done}, 0);
    rst = 0;
    sb.delete();

    // clean sweep after reset
    run_sweep(5'd1, 5'd1, 1, 0, 0, NOERR, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ahb_gnss_search_sequencer.md
Name: ahb_gnss_search_sequencer

Overview:
- AHB-Lite manager that drives the GNSS search register block (0x2004_0100..0x2004_0110) without CPU involvement.
- Sweeps a PRN range. For each SV it: writes the SV register, starts the search, polls status until done, reads DOP/code/correlation, then emits one result record on a valid/ready stream.
- Sits on the AHB fabric as a second manager beside the CPU; results feed the acquisition table.

Parameters:
- BASE_ADDR, 32'h2004_0100, address of the status/start register; other registers at +4, +8, +C, +10.
- POLL_GAP, 16, idle cycles between status polls (>=1).
- POLL_LIMIT, 4096, max status polls per SV before timeout (>=1).

Ports:
- hclk  in  1  bus clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a sweep. Ignored while busy.
- sv_first  in  5  first SV of sweep; sampled on start.
- sv_last  in  5  last SV of sweep, inclusive; sampled on start.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when the sweep ends (normal or error).
- bus_err  out  1  sticky; set on an HRESP error; cleared by start.
- haddr  out  32  AHB address.
- htrans  out  2  IDLE or NONSEQ only.
- hwrite  out  1  transfer direction.
- hsize  out  2  constant 2'b10 (word).
- hburst  out  3  constant 3'b000 (SINGLE).
- hwdata  out  32  write data, data phase.
- hrdata  in  32  read data.
- hready  in  1  transfer complete / bus available.
- hresp  in  1  1 = error.
- res_valid  out  1  result record valid.
- res_ready  in  1  consumer accepts record.
- res_sv  out  5  SV of record.
- res_dop  out  32  DOP word.
- res_code  out  32  code-phase word.
- res_corr  out  32  correlation word.
- res_timeout  out  1  poll limit hit; data words are 0.

Behaviour:
- Reset values: htrans=IDLE, haddr=0, hwrite=0, hwdata=0, busy=0, sweep_done=0, bus_err=0, res_valid=0, all res_* fields=0, FSM=IDLE.
- Transfer engine: one outstanding transfer, no pipelining.
- Address phase: drive NONSEQ with haddr/hwrite; hold until sampled with hready=1.
- Data phase: the next cycle. Drive htrans=IDLE. Drive hwdata for writes, held stable. Wait until hready=1, then capture hrdata for reads.
- hresp=1 in any data phase: abort the transfer, set bus_err, go to FINISH. No result is emitted for the current SV.
- Main FSM states: IDLE, WR_SV, WR_START, GAP, RD_STATUS, RD_DOP, RD_CODE, RD_CORR, EMIT, FINISH.
- IDLE: on start, latch sv_first/sv_last, clear bus_err, set busy, go to WR_SV with cur_sv=sv_first.
- sv_first>sv_last: the sweep ends after sv_first alone, as if sv_last=sv_first.
- WR_SV: write {27'b0,cur_sv} to BASE+4.
- WR_START: write 32'h3 to BASE+0. This starts the search and clears done. Reset the poll counter, then go to GAP.
- GAP: wait POLL_GAP cycles, then go to RD_STATUS.
- RD_STATUS: read BASE+0.
  - If bit1 is set, go to RD_DOP.
  - Else increment the poll counter. At POLL_LIMIT, set the timeout flag, zero the data fields and go to EMIT. Otherwise go to GAP.
- RD_DOP, RD_CODE, RD_CORR: read BASE+8, BASE+C, BASE+10 into the result fields.
- EMIT: res_valid=1 with fields stable until res_ready=1.
  - Transfer occurs in the cycle where res_valid and res_ready are both 1.
  - Next cycle: if cur_sv==sv_last go to FINISH, else cur_sv+1 and go to WR_SV.
  - No bus activity (htrans=IDLE) while stalled.
- FINISH: one cycle; pulse sweep_done, clear busy, go to IDLE.
- cur_sv is 5-bit. A sweep ending at SV 31 must terminate by the equality check, not wrap to 0.
- rst mid-transfer: all outputs return to reset values the next cycle. The subordinate is responsible for recovering.
- start while busy: no effect.

Decomposition:
- Shared gnss package:
  - register offset constants: SEARCH_STATUS=0x0, SEARCH_SV=0x4, SEARCH_DOP=0x8, SEARCH_CODE=0xC, SEARCH_CORR=0x10;
  - status bit indices: START=0, DONE=1;
  - existing sv_t, word_t, htrans_t.
- One sub-module: ahb_single_master. It owns the address/data phase engine: req/addr/write/wdata in; done/rdata/err out.

Test Plan:
- Sweep 3..3, zero-wait subordinate model, done after 2 polls -> exact sequence: W 0x2004_0104=3, W 0x2004_0100=3, R status x2, R 0x108/0x10C/0x110. One record: sv=3, matching data, timeout=0. Then sweep_done.
- Sweep 30..31 with random hready stalls (0-3 cycles) -> 2 records, sv 30 then 31. haddr/hwdata stable while hready=0. No wrap to SV 0.
- Model never sets done, POLL_LIMIT=4 -> exactly 4 status reads. Record res_timeout=1, data=0. Sweep continues to the next SV.
- hresp=1 on the RD_CODE data phase -> bus_err=1, no record, sweep_done pulse, busy=0. Next start clears bus_err.
- res_ready held low 20 cycles in EMIT -> fields stable, htrans=IDLE throughout. Resumes one cycle after acceptance.
- rst asserted during a WR_START data phase -> next cycle htrans=IDLE, busy=0, res_valid=0.
